// File: rtl/stream_capture_mux.sv
// Multi-channel stream capture: per-channel FIFOs drained round-robin into framed OUT_W-wide beats.
// Optional macro CAPTURE_BACKPRESSURE_EN drives ch_full_n from FIFO occupancy instead of tying it high.
module stream_capture_mux #(
  parameter int NUM_CH = 2,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16,
  parameter int OUT_W  = 4
) (
  input  logic                     ap_clk,
  input  logic                     ap_rst,
  input  logic [NUM_CH-1:0]        ch_write,
  input  logic [NUM_CH*DATA_W-1:0] ch_din,
  output logic [NUM_CH-1:0]        ch_full_n,
  output logic [OUT_W-1:0]         data_out,
  output logic                     data_valid,
  output logic                     data_sof,
  output logic                     probe_out
);

  localparam int BEATS  = DATA_W / OUT_W;
  localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W  = PTR_W + 1;
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int BCNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef enum logic [1:0] {IDLE, HDR, DATA} state_t;

  logic [NUM_CH-1:0]             nonempty;
  logic [NUM_CH-1:0]             full;
  logic [NUM_CH-1:0]             wr_acc;
  logic [NUM_CH-1:0]             wr_rej;
  logic [NUM_CH-1:0]             pop;
  logic [NUM_CH-1:0][DATA_W-1:0] head;

  // Stage p0: per-channel FIFOs; full is judged on the registered count, before any pop.
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_nxt;

    assign full[i]     = (cnt == CNT_W'(DEPTH));
    assign nonempty[i] = (cnt != '0);
    assign wr_acc[i]   = ch_write[i] & ~full[i];
    assign wr_rej[i]   = ch_write[i] & full[i];
    assign head[i]     = mem[rd_ptr];

    always_comb begin
      cnt_nxt = cnt;
      if (wr_acc[i] && !pop[i]) begin
        cnt_nxt = cnt + 1'b1;
      end else if (!wr_acc[i] && pop[i]) begin
        cnt_nxt = cnt - 1'b1;
      end
    end

    always_ff @(posedge ap_clk) begin
      if (ap_rst) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        cnt    <= '0;
      end else begin
        if (wr_acc[i]) wr_ptr <= wr_ptr + 1'b1;
        if (pop[i])    rd_ptr <= rd_ptr + 1'b1;
        cnt <= cnt_nxt;
      end
    end

    always_ff @(posedge ap_clk) begin
      if (wr_acc[i]) mem[wr_ptr] <= ch_din[i*DATA_W +: DATA_W];
    end

`ifdef CAPTURE_BACKPRESSURE_EN
    logic full_n_q;
    always_ff @(posedge ap_clk) begin
      if (ap_rst) full_n_q <= 1'b1;
      else        full_n_q <= (cnt_nxt != CNT_W'(DEPTH));
    end
    assign ch_full_n[i] = full_n_q;
`else
    assign ch_full_n[i] = 1'b1;
`endif
  end

  // Round-robin pick: first non-empty channel after the one served last.
  logic [CH_W-1:0] last_ch;
  logic [CH_W-1:0] sel;
  logic [CH_W-1:0] cand;
  logic            found;

  always_comb begin
    found = 1'b0;
    sel   = last_ch;
    cand  = '0;
    for (int k = 1; k <= NUM_CH; k++) begin
      cand = CH_W'((int'(last_ch) + k) % NUM_CH);
      if (!found && nonempty[cand]) begin
        found = 1'b1;
        sel   = cand;
      end
    end
  end

  // Stage p1: framing FSM and shift register feeding the registered pin outputs.
  state_t            state, state_nxt;
  logic [CH_W-1:0]   last_ch_nxt;
  logic [CH_W-1:0]   chan_p1, chan_nxt;
  logic [DATA_W-1:0] shreg_p1, shreg_nxt;
  logic [BCNT_W-1:0] beat_p1, beat_nxt;
  logic [OUT_W-1:0]  dout_nxt;
  logic              vld_nxt;
  logic              sof_nxt;

  always_comb begin
    state_nxt   = state;
    last_ch_nxt = last_ch;
    chan_nxt    = chan_p1;
    shreg_nxt   = shreg_p1;
    beat_nxt    = beat_p1;
    dout_nxt    = '0;
    vld_nxt     = 1'b0;
    sof_nxt     = 1'b0;
    pop         = '0;
    case (state)
      IDLE: begin
        if (found) begin
          pop[sel]    = 1'b1;
          shreg_nxt   = head[sel];
          chan_nxt    = sel;
          last_ch_nxt = sel;
          state_nxt   = HDR;
        end
      end
      HDR: begin
        dout_nxt  = OUT_W'(chan_p1);
        vld_nxt   = 1'b1;
        sof_nxt   = 1'b1;
        beat_nxt  = '0;
        state_nxt = DATA;
      end
      DATA: begin
        dout_nxt  = shreg_p1[DATA_W-1 -: OUT_W];
        vld_nxt   = 1'b1;
        shreg_nxt = shreg_p1 << OUT_W;
        beat_nxt  = beat_p1 + 1'b1;
        if (beat_p1 == BCNT_W'(BEATS - 1)) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state      <= IDLE;
      last_ch    <= CH_W'(NUM_CH - 1);
      beat_p1    <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      data_sof   <= 1'b0;
      probe_out  <= 1'b0;
    end else begin
      state      <= state_nxt;
      last_ch    <= last_ch_nxt;
      beat_p1    <= beat_nxt;
      data_out   <= dout_nxt;
      data_valid <= vld_nxt;
      data_sof   <= sof_nxt;
      if (|wr_rej) probe_out <= 1'b1;
    end
  end

  always_ff @(posedge ap_clk) begin
    chan_p1  <= chan_nxt;
    shreg_p1 <= shreg_nxt;
  end

endmodule

// File: tb/tb_stream_capture_mux.sv
// Bench for stream_capture_mux: queue-based frame model checked every cycle, plus literal frame checks.
module tb_stream_capture_mux;
  localparam int NUM_CH = 2;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 16;
  localparam int OUT_W  = 4;
  localparam int BEATS  = DATA_W / OUT_W;
  localparam int LOGN   = 512;

  logic                     ap_clk = 1'b0;
  logic                     ap_rst = 1'b1;
  logic [NUM_CH-1:0]        ch_write = '0;
  logic [NUM_CH*DATA_W-1:0] ch_din = '0;
  logic [NUM_CH-1:0]        ch_full_n;
  logic [OUT_W-1:0]         data_out;
  logic                     data_valid;
  logic                     data_sof;
  logic                     probe_out;

  always #5 ap_clk = ~ap_clk;

  stream_capture_mux #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .DEPTH(DEPTH), .OUT_W(OUT_W)) dut (
    .ap_clk(ap_clk), .ap_rst(ap_rst), .ch_write(ch_write), .ch_din(ch_din),
    .ch_full_n(ch_full_n), .data_out(data_out), .data_valid(data_valid),
    .data_sof(data_sof), .probe_out(probe_out)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  // Model: word queues per channel and a schedule of beats still to be shown on the pins.
  logic [DATA_W-1:0] mq [NUM_CH][$];
  logic [OUT_W:0]    sched[$];
  int                m_last = NUM_CH - 1;
  bit                m_ovf = 1'b0;
  bit                m_vld = 1'b0;
  bit                m_sof = 1'b0;
  logic [OUT_W-1:0]  m_out = '0;

  logic [OUT_W-1:0]  lg_out [LOGN];
  bit                lg_vld [LOGN];
  bit                lg_sof [LOGN];
  bit                lg_prb [LOGN];
  logic [NUM_CH-1:0] lg_full [LOGN];

  int                dut_ch[$];
  logic [DATA_W-1:0] dut_word[$];
  bit                fr_open = 1'b0;
  int                fr_ch = 0;
  int                fr_beats = 0;
  logic [DATA_W-1:0] fr_acc = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s cyc_ref=%0d actual=%0h required=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic model_edge(input logic [NUM_CH-1:0] w, input logic [NUM_CH*DATA_W-1:0] d,
                            input logic r);
    int pre [NUM_CH];
    bit idle;
    bit got;
    int c;
    logic [OUT_W:0] e;
    logic [DATA_W-1:0] word;
    if (r) begin
      for (int ch = 0; ch < NUM_CH; ch++) mq[ch].delete();
      sched.delete();
      m_ovf = 1'b0; m_last = NUM_CH - 1;
      m_vld = 1'b0; m_sof = 1'b0; m_out = '0;
      return;
    end
    for (int ch = 0; ch < NUM_CH; ch++) pre[ch] = mq[ch].size();
    idle = (sched.size() == 0);
    if (idle) begin
      m_vld = 1'b0; m_sof = 1'b0; m_out = '0;
      got = 1'b0;
      for (int k = 1; k <= NUM_CH; k++) begin
        c = (m_last + k) % NUM_CH;
        if (!got && mq[c].size() > 0) begin
          got = 1'b1;
          word = mq[c].pop_front();
          m_last = c;
          sched.push_back({1'b1, OUT_W'(c)});
          for (int b = 0; b < BEATS; b++)
            sched.push_back({1'b0, word[DATA_W-1-b*OUT_W -: OUT_W]});
        end
      end
    end else begin
      e = sched.pop_front();
      m_vld = 1'b1; m_sof = e[OUT_W]; m_out = e[OUT_W-1:0];
    end
    for (int ch = 0; ch < NUM_CH; ch++) begin
      if (w[ch]) begin
        if (pre[ch] >= DEPTH) m_ovf = 1'b1;
        else mq[ch].push_back(d[ch*DATA_W +: DATA_W]);
      end
    end
  endtask

  task automatic compare();
    logic [NUM_CH-1:0] m_full;
    for (int ch = 0; ch < NUM_CH; ch++) begin
`ifdef CAPTURE_BACKPRESSURE_EN
      m_full[ch] = (mq[ch].size() != DEPTH);
`else
      m_full[ch] = 1'b1;
`endif
    end
    n_checks++;
    if ({ch_full_n, probe_out, data_valid, data_sof, data_out} !==
        {m_full, m_ovf, m_vld, m_sof, m_out}) begin
      n_errors++;
      $display("FAIL cycle_cmp cyc=%0d actual out=%h vld=%b sof=%b probe=%b full_n=%b required out=%h vld=%b sof=%b probe=%b full_n=%b",
               cyc, data_out, data_valid, data_sof, probe_out, ch_full_n,
               m_out, m_vld, m_sof, m_ovf, m_full);
    end
  endtask

  task automatic tick(input logic [NUM_CH-1:0] w, input logic [NUM_CH*DATA_W-1:0] d,
                      input logic r);
    ch_write = w; ch_din = d; ap_rst = r;
    @(posedge ap_clk);
    model_edge(w, d, r);
    #1;
    compare();
    if (cyc >= 0 && cyc < LOGN) begin
      lg_out[cyc] = data_out; lg_vld[cyc] = data_valid; lg_sof[cyc] = data_sof;
      lg_prb[cyc] = probe_out; lg_full[cyc] = ch_full_n;
    end
    if (r) begin
      fr_open = 1'b0;
    end else if (data_valid && data_sof) begin
      fr_open = 1'b1; fr_ch = int'(data_out); fr_beats = 0; fr_acc = '0;
    end else if (data_valid && fr_open) begin
      fr_acc = {fr_acc[DATA_W-OUT_W-1:0], data_out};
      fr_beats++;
      if (fr_beats == BEATS) begin
        dut_ch.push_back(fr_ch); dut_word.push_back(fr_acc); fr_open = 1'b0;
      end
    end
    cyc++;
  endtask

  task automatic idle_ticks(input int n);
    for (int k = 0; k < n; k++) tick('0, '0, 1'b0);
  endtask

  task automatic start_test();
    tick('0, '0, 1'b1);
    tick('0, '0, 1'b1);
    dut_ch.delete(); dut_word.delete();
    cyc = 0;
  endtask

  function automatic logic [63:0] pk(input int c);
    return 64'({lg_vld[c], lg_sof[c], lg_out[c]});
  endfunction

  initial begin
    logic [NUM_CH*DATA_W-1:0] dv;
    int sent;
    int guard;
    int nv;

    // Reset state
    start_test();
    chk("reset_state", 64'({data_valid, data_sof, data_out, probe_out, ch_full_n}),
        64'({1'b0, 1'b0, 4'h0, 1'b0, 2'b11}));

    // Single word on ch0
    dv = '0; dv[0 +: DATA_W] = 32'h1234_5678;
    tick(2'b01, dv, 1'b0);
    idle_ticks(14);
    chk("single_pop_quiet", pk(1), 64'({1'b0, 1'b0, 4'h0}));
    chk("single_hdr", pk(2), 64'({1'b1, 1'b1, 4'h0}));
    for (int k = 0; k < BEATS; k++)
      chk("single_data", pk(3 + k), 64'({1'b1, 1'b0, OUT_W'(k + 1)}));
    chk("single_gap", 64'(lg_vld[11]), 64'(0));

    // Simultaneous writes on both channels
    start_test();
    dv = '0; dv[0 +: DATA_W] = 32'hAAAA_AAAA; dv[DATA_W +: DATA_W] = 32'h5555_5555;
    tick(2'b11, dv, 1'b0);
    idle_ticks(24);
    chk("sim_hdr0", pk(2), 64'({1'b1, 1'b1, 4'h0}));
    chk("sim_data0", pk(6), 64'({1'b1, 1'b0, 4'hA}));
    chk("sim_last0", pk(10), 64'({1'b1, 1'b0, 4'hA}));
    chk("sim_gap", 64'(lg_vld[11]), 64'(0));
    chk("sim_hdr1", pk(12), 64'({1'b1, 1'b1, 4'h1}));
    chk("sim_data1", pk(13), 64'({1'b1, 1'b0, 4'h5}));
    chk("sim_last1", pk(20), 64'({1'b1, 1'b0, 4'h5}));
    chk("sim_gap2", 64'(lg_vld[21]), 64'(0));

    // Fairness: four words per channel back-to-back
    start_test();
    for (int k = 0; k < 4; k++) begin
      dv = '0;
      dv[0 +: DATA_W] = 32'hC000_0000 + 32'(k);
      dv[DATA_W +: DATA_W] = 32'hD000_0000 + 32'(k);
      tick(2'b11, dv, 1'b0);
    end
    idle_ticks(96);
    chk("fair_frames", 64'(dut_ch.size()), 64'(8));
    for (int f = 0; f < 8 && f < dut_ch.size(); f++) begin
      chk("fair_hdr", 64'(dut_ch[f]), 64'(f % 2));
      chk("fair_word", 64'(dut_word[f]),
          64'(((f % 2) ? 32'hD000_0000 : 32'hC000_0000) + 32'(f / 2)));
    end

    // Ch1 burst of 20 words; writes issued only while ch_full_n[1] is high
    start_test();
    sent = 0; guard = 0;
    while (sent < 20 && guard < 400) begin
      if (ch_full_n[1]) begin
        dv = '0; dv[DATA_W +: DATA_W] = 32'hE000_0000 + 32'(sent);
        tick(2'b10, dv, 1'b0);
        sent++;
      end else begin
        tick('0, '0, 1'b0);
      end
      guard++;
    end
    chk("burst_budget", 64'(sent), 64'(20));
    idle_ticks(220);
`ifdef CAPTURE_BACKPRESSURE_EN
    chk("bp_frames", 64'(dut_ch.size()), 64'(20));
    chk("bp_full_before", 64'(lg_full[16][1]), 64'(1));
    chk("bp_full_drop", 64'(lg_full[18][1]), 64'(0));
    chk("bp_probe", 64'(probe_out), 64'(0));
    for (int f = 0; f < 20 && f < dut_ch.size(); f++)
      chk("bp_word", 64'(dut_word[f]), 64'(32'hE000_0000 + 32'(f)));
`else
    chk("ovf_frames", 64'(dut_ch.size()), 64'(18));
    chk("ovf_probe_pre", 64'(lg_prb[17]), 64'(0));
    chk("ovf_probe_set", 64'(lg_prb[19]), 64'(1));
    chk("ovf_probe_end", 64'(probe_out), 64'(1));
    for (int f = 0; f < 18 && f < dut_ch.size(); f++)
      chk("ovf_word", 64'(dut_word[f]), 64'(32'hE000_0000 + 32'(f)));
`endif

    // Reset in the middle of a single-word frame
    start_test();
    dv = '0; dv[0 +: DATA_W] = 32'h1234_5678;
    tick(2'b01, dv, 1'b0);
    idle_ticks(4);
    tick('0, '0, 1'b1);
    chk("midrst_outputs", 64'({lg_vld[5], lg_sof[5], lg_out[5], lg_prb[5], lg_full[5]}),
        64'({1'b0, 1'b0, 4'h0, 1'b0, 2'b11}));
    idle_ticks(20);
    nv = 0;
    for (int c = 6; c < 26; c++) if (lg_vld[c]) nv++;
    chk("midrst_no_beats", 64'(nv), 64'(0));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
